pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: id_SrcReg1, id_SrcReg2  in  4  source registers of the instruction in ID.
REQ-004 SHALL provide: id_use1, id_use2  in  1  the instruction in ID reads id_SrcReg1 / id_SrcReg2.
REQ-005 SHALL provide: ex_Data_Mem_en, ex_Data_Mem_wr, ex_WriteReg  in  1  control bits currently held in ID/EX.
REQ-006 SHALL provide: ex_DstReg  in  4  destination register currently held in ID/EX.
REQ-007 SHALL provide: branch_taken  in  1  the branch in ID resolved taken.
REQ-008 SHALL provide: id_halt  in  1  HLT decoded in ID.
REQ-009 SHALL provide: dmem_wait  in  1  data memory has not completed its access this cycle.
REQ-010 SHALL provide: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  write enables for PC and the pipeline registers.
REQ-011 SHALL provide: ifid_flush  out  1  IF/ID loads a NOP.
REQ-012 SHALL provide: idex_bubble  out  1  ID/EX loads zeroed control bits (Data_Mem_en, Data_Mem_wr, WriteReg = 0).
REQ-013 SHALL provide: halted  out  1  pipeline drained after HLT.

Function
REQ-014 SHALL define load_use = ex_Data_Mem_en & ~ex_Data_Mem_wr & ex_WriteReg & (ex_DstReg != 0) & ((id_use1 & id_SrcReg1 == ex_DstReg) | (id_use2 & id_SrcReg2 == ex_DstReg)).
REQ-015 SHALL implement registered states RUN, MEM_WAIT, DRAIN and HALTED; all outputs combinational from state and inputs (zero-cycle latency).
REQ-016 In RUN with no event: all five enables 1, ifid_flush 0, idex_bubble 0.
REQ-017 In RUN, priority SHALL be dmem_wait > id_halt > load_use > branch_taken.
REQ-018 RUN & dmem_wait: all enables 0; next state MEM_WAIT. MEM_WAIT: all enables 0 while dmem_wait; on dmem_wait=0, RUN outputs apply that cycle and next state is RUN.
REQ-019 RUN & load_use: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=memwb_en=1; exactly one bubble per load-use pair.
REQ-020 RUN & branch_taken (no higher event): ifid_flush=1 for one cycle, all enables 1.
REQ-021 RUN & id_halt: pc_en=0, ifid_en=0, idex_bubble=1, drain counter loaded with 3, next state DRAIN.
REQ-022 DRAIN: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=memwb_en=1; counter decrements per cycle; at 0, next state HALTED.
REQ-023 In DRAIN, dmem_wait SHALL force all enables 0 and freeze the counter.
REQ-024 HALTED: all enables 0, halted=1; exit only by reset.
REQ-025 branch_taken and id_halt together: halt wins, no flush.

Reset
REQ-026 While rst=0, state SHALL be RUN, counter 0, and all outputs 0 (halted=0).
REQ-027 Reset asserted in any state, including mid-DRAIN or MEM_WAIT, SHALL abandon that state immediately.
REQ-028 After rst deassertion, RUN behaviour SHALL apply from the first rising edge.

Configuration
REQ-029 With PIPE_STALL_CNT_EN defined: additional output stall_count (out, 16) counts cycles with pc_en=0 outside HALTED, saturates at 0xFFFF, and resets to 0.
REQ-030 Without PIPE_STALL_CNT_EN: port and counter absent; all other behaviour identical.

Verification
REQ-031 LDR into R3 in ID/EX, ID reads R3 (id_use1=1) -> one cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle all enables 1.
REQ-032 Same load with ex_DstReg=0, or a store (ex_Data_Mem_wr=1) -> no stall.
REQ-033 branch_taken=1 for one cycle -> ifid_flush=1 that cycle only, pc_en=1.
REQ-034 dmem_wait held 4 cycles during load_use -> enables 0 for 4 cycles, then one bubble cycle.
REQ-035 id_halt -> 4 cycles pc_en=0 with idex_bubble=1, then halted=1 holding; rst pulse in DRAIN -> outputs 0, then RUN.
REQ-036 With PIPE_STALL_CNT_EN: two load-use stalls plus 3 dmem_wait cycles -> stall_count=5.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and halt-drain control for a 5-stage pipeline.
// Optional PIPE_STALL_CNT_EN adds a saturating stall_count output.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_SrcReg1,
  input  logic [3:0] id_SrcReg2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic       ex_Data_Mem_en,
  input  logic       ex_Data_Mem_wr,
  input  logic       ex_WriteReg,
  input  logic [3:0] ex_DstReg,
  input  logic       branch_taken,
  input  logic       id_halt,
  input  logic       dmem_wait,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       halted
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3;
  logic [1:0] state_q, state_d, cnt_q, cnt_d;
  logic       load_use;
  assign load_use = ex_Data_Mem_en & ~ex_Data_Mem_wr & ex_WriteReg & (ex_DstReg != 4'd0) &
                    ((id_use1 & (id_SrcReg1 == ex_DstReg)) | (id_use2 & (id_SrcReg2 == ex_DstReg)));
  // MEM_WAIT behaves as RUN once the memory completes, so both share one branch.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (!rst) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else if (state_q == RUN || state_q == MEM_WAIT) begin
      if (dmem_wait) begin
        state_d = MEM_WAIT;
      end else begin
        state_d  = RUN;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        if (id_halt) begin
          idex_bubble = 1'b1;
          cnt_d       = 2'd3;
          state_d     = DRAIN;
        end else if (load_use) begin
          idex_bubble = 1'b1;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = branch_taken;
        end
      end
    end else if (state_q == DRAIN) begin
      idex_bubble = 1'b1;
      if (!dmem_wait) begin
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        cnt_d    = cnt_q - 2'd1;
        state_d  = (cnt_q == 2'd1) ? HALTED : DRAIN;
      end
    end else begin
      halted = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;
  always_comb begin
    stall_count_d = (!pc_en && state_q != HALTED && stall_count_q != 16'hFFFF) ?
                    stall_count_q + 16'd1 : stall_count_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_count_q <= 16'd0;
    else      stall_count_q <= stall_count_d;
  end
  assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, flush, drain and reset behaviour.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] id_SrcReg1 = 4'd0, id_SrcReg2 = 4'd0, ex_DstReg = 4'd0;
  logic       id_use1 = 1'b0, id_use2 = 1'b0;
  logic       ex_Data_Mem_en = 1'b0, ex_Data_Mem_wr = 1'b0, ex_WriteReg = 1'b0;
  logic       branch_taken = 1'b0, id_halt = 1'b0, dmem_wait = 1'b0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, halted;
  int         n_checks = 0, n_fails = 0;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_SrcReg1(id_SrcReg1), .id_SrcReg2(id_SrcReg2),
    .id_use1(id_use1), .id_use2(id_use2),
    .ex_Data_Mem_en(ex_Data_Mem_en), .ex_Data_Mem_wr(ex_Data_Mem_wr),
    .ex_WriteReg(ex_WriteReg), .ex_DstReg(ex_DstReg),
    .branch_taken(branch_taken), .id_halt(id_halt), .dmem_wait(dmem_wait),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halted(halted)
`ifdef PIPE_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected vector order: pc, ifid, idex, exmem, memwb, flush, bubble, halted.
  localparam logic [7:0] NONE = 8'b0000_0000, RUNV = 8'b1111_1000, BUB = 8'b0011_1010,
                         FLUSH = 8'b1111_1100, HALTV = 8'b0000_0001, DWAIT = 8'b0000_0010;

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    #1;
    obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, halted};
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [3:0] dst, input logic wr);
    ex_Data_Mem_en = 1'b1;
    ex_Data_Mem_wr = wr;
    ex_WriteReg    = 1'b1;
    ex_DstReg      = dst;
  endtask

  task automatic ex_clear();
    ex_Data_Mem_en = 1'b0;
    ex_Data_Mem_wr = 1'b0;
    ex_WriteReg    = 1'b0;
    ex_DstReg      = 4'd0;
  endtask

  initial begin
    branch_taken = 1'b1;
    dmem_wait    = 1'b0;
    chk("reset_outputs", NONE);
    tick();
    chk("reset_held", NONE);
    rst = 1'b1;
    branch_taken = 1'b0;
    chk("run_idle", RUNV);
    tick();
    ld(4'd3, 1'b0); id_SrcReg1 = 4'd3; id_use1 = 1'b1;
    chk("load_use_src1", BUB);
    tick();
    ex_clear();
    chk("after_bubble", RUNV);
    tick();
    ld(4'd0, 1'b0); id_SrcReg1 = 4'd0;
    chk("load_r0_no_stall", RUNV);
    ld(4'd3, 1'b1); id_SrcReg1 = 4'd3;
    chk("store_no_stall", RUNV);
    ld(4'd3, 1'b0); id_use1 = 1'b0;
    chk("src_unused_no_stall", RUNV);
    id_SrcReg2 = 4'd3; id_use2 = 1'b1;
    chk("load_use_src2", BUB);
    tick();
    ex_clear(); id_use2 = 1'b0; id_SrcReg2 = 4'd0;
    branch_taken = 1'b1;
    chk("branch_flush", FLUSH);
    tick();
    branch_taken = 1'b0;
    chk("flush_one_cycle", RUNV);
    ld(4'd5, 1'b0); id_SrcReg1 = 4'd5; id_use1 = 1'b1; branch_taken = 1'b1;
    chk("load_use_over_branch", BUB);
    branch_taken = 1'b0;
    dmem_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("dmem_wait_freeze", NONE);
      tick();
    end
    dmem_wait = 1'b0;
    chk("bubble_after_wait", BUB);
    tick();
    ex_clear(); id_use1 = 1'b0;
    chk("run_after_wait", RUNV);
    id_halt = 1'b1; branch_taken = 1'b1;
    chk("halt_over_branch", BUB);
    tick();
    id_halt = 1'b0; branch_taken = 1'b0;
    chk("drain_1", BUB);
    tick();
    dmem_wait = 1'b1;
    chk("drain_wait", DWAIT);
    tick();
    dmem_wait = 1'b0;
    chk("drain_2", BUB);
    tick();
    chk("drain_3", BUB);
    tick();
    chk("halted", HALTV);
    branch_taken = 1'b1;
    tick();
    chk("halted_hold", HALTV);
    branch_taken = 1'b0;
    rst = 1'b0;
    chk("reset_from_halted", NONE);
    tick();
    rst = 1'b1;
    chk("run_after_reset", RUNV);
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0;
    chk("drain_before_reset", BUB);
    #2 rst = 1'b0;
    chk("reset_mid_drain", NONE);
    #2 rst = 1'b1;
    chk("run_after_drain_reset", RUNV);
    tick();
    chk("run_next_edge", RUNV);
    dmem_wait = 1'b1;
    tick();
    chk("mem_wait_state", NONE);
    #2 rst = 1'b0;
    dmem_wait = 1'b0;
    chk("reset_mid_wait", NONE);
    tick();
    rst = 1'b1;
    branch_taken = 1'b1;
    chk("branch_after_wait_reset", FLUSH);
    tick();
    branch_taken = 1'b0;
`ifdef PIPE_STALL_CNT_EN
    rst = 1'b0;
    #2 rst = 1'b1;
    ld(4'd7, 1'b0); id_SrcReg1 = 4'd7; id_use1 = 1'b1;
    tick();
    ex_clear();
    tick();
    ld(4'd7, 1'b0);
    tick();
    ex_clear(); dmem_wait = 1'b1;
    repeat (3) tick();
    dmem_wait = 1'b0;
    tick();
    n_checks++;
    assert (stall_count === 16'd5) else begin
      n_fails++;
      $error("FAIL stall_count: observed %0d expected 5", stall_count);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
